calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
Instruction sequencer for the complex calculator datapath: register bank, ALU and the rec2pol CORDIC unit.
- Accepts one 16-bit instruction per handshake.
- Drives register-bank read selects, starts the ALU or CORDIC, waits for completion and writes the result back.
- Sits between the host/instruction source and the datapath; it owns every datapath control strobe.

Parameters:
CORDIC_LAT, 32, cycles from cordic_start until mod/angle are valid
ALU_TIMEOUT, 64, max cycles waiting for alu_done before abort
IMM_W, 64, width of immediate load word

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction offered
instr  in  16  {opcode[15:12], dst[11:8], srcA[7:4], srcB[3:0]}
instr_ready  out  1  controller can accept instruction
seloutA  out  4  reg-bank read select A
seloutB  out  4  reg-bank read select B
enrregA  out  1  reg-bank output-register enable A
enrregB  out  1  reg-bank output-register enable B
selwreg  out  4  reg-bank write select
regwen  out  1  reg-bank write enable (1-cycle pulse)
wb_sel  out  2  write-back mux: 0 ALU, 1 CORDIC {mod,angle}, 2 immediate
opr  out  4  ALU operation code
alu_start  out  1  ALU start (1-cycle pulse)
alu_done  in  1  ALU result valid
cordic_start  out  1  rec2pol start (1-cycle pulse)
cordic_enable  out  1  rec2pol enable
cmp_flag  out  1  result bit of last compare
busy  out  1  instruction in flight
done  out  1  1-cycle pulse when instruction retires
err  out  1  sticky error; cleared by reset or next accepted instruction

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs are 0 except instr_ready=0 and cmp_flag=0; counters are 0. Reset mid-instruction aborts it with no write-back. instr_ready rises the first clock after release.
- Opcodes:
  - 0-7: ALU ops with write-back; opr=opcode.
  - 8: ALU compare. No write-back; cmp_flag<=alu result bit0, supplied on port alu_res0 (in, 1) and sampled with alu_done.
  - 9: rec2pol on srcA.
  - 10: LOADI, write-back from the immediate mux, no execution.
  - 15: NOP, retires immediately.
  - 11-14: illegal. Set err, retire, no write-back.
- FSM: IDLE -> READ -> ISSUE -> WAIT -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr, clear err, go to READ. NOP retires from IDLE with a done pulse the next cycle.
- READ (1 cycle): drive seloutA/seloutB from the latched instr and assert enrregA/B=1. Selects hold until retire.
- ISSUE (1 cycle):
  - ALU ops: alu_start=1.
  - Op 9: cordic_start=1 and cordic_enable=1.
  - LOADI: go straight to WB.
- WAIT, ALU ops:
  - Sample alu_done, starting the cycle after ISSUE. A done coinciding with ISSUE is ignored.
  - Timeout counter increments each WAIT cycle. Reaching ALU_TIMEOUT sets err and returns to IDLE with a done pulse and no WB.
- WAIT, CORDIC: cordic_enable stays 1. The counter counts to CORDIC_LAT-1, then goes to WB. cordic_enable drops on WB entry.
- WB (1 cycle): regwen=1, selwreg=dst, wb_sel per opcode. done=1 in the following IDLE cycle.
- busy=1 in every state except IDLE.
- Latency:
  - ALU op with done D cycles after start: D+4 cycles from accept to done.
  - CORDIC: CORDIC_LAT+4 cycles.
  - LOADI: 4 cycles.
- Back-to-back: a new instruction may be accepted in the same cycle done is asserted.
- dst==srcA is legal: operands are captured in READ before WB.

Test Plan:
- LOADI R0=20+20i, LOADI R1=20+20i, ADD(2) dst R2 -> regwen pulse with selwreg=2, wb_sel=0, done 4+D cycles after accept; R2 reads 40+40i.
- SUB(3) R3=R0-R1 -> R3=0+0i. MUL(4) R4=R0*R1 -> R4=0+800i.
- CMP(8) R0,R1 -> cmp_flag=1, no regwen. CMP R0,R3 -> cmp_flag=0.
- Op 9 on R0 (20+20i) -> cordic_enable high exactly CORDIC_LAT+1 cycles; WB with wb_sel=1; mod≈28.284, angle≈45.0 deg.
- ALU model never asserts alu_done -> err=1 after 64 WAIT cycles, done pulse, no regwen. Opcode 12 -> err=1, no regwen.
- reset=0 asserted mid-WAIT of MUL -> outputs zero immediately, no regwen. After release, a new ADD completes normally.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Instruction sequencer for the complex calculator: decodes one instruction, drives reg-bank/ALU/CORDIC strobes, writes back.
// Latency accept->done: NOP 1, illegal 3, LOADI 4, ALU D+4, CORDIC CORDIC_LAT+4, ALU timeout ALU_TIMEOUT+3.
// Backpressure: instr_ready only in IDLE (one instruction in flight); a new instruction may be taken in the done cycle.
module calc_seq_ctrl #(
    parameter int CORDIC_LAT  = 32,
    parameter int ALU_TIMEOUT = 64,
    parameter int IMM_W       = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  seloutA,
    output logic [3:0]  seloutB,
    output logic        enrregA,
    output logic        enrregB,
    output logic [3:0]  selwreg,
    output logic        regwen,
    output logic [1:0]  wb_sel,
    output logic [3:0]  opr,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic        alu_res0,
    output logic        cordic_start,
    output logic        cordic_enable,
    output logic        cmp_flag,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // One shared wait counter serves both the ALU timeout and the CORDIC latency.
    localparam int CNT_MAX = (CORDIC_LAT > ALU_TIMEOUT) ? CORDIC_LAT : ALU_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] COR_LAST = CNT_W'(CORDIC_LAT - 1);
    localparam logic [CNT_W-1:0] ALU_LAST = CNT_W'(ALU_TIMEOUT - 1);

    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_COR = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_NOP = 4'd15;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_COR = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    // The immediate word itself flows through the datapath mux; the sequencer only
    // selects it. A non-positive width is a configuration error with no legal hardware.
    if (IMM_W < 1) begin : g_imm_w_invalid
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      instr_q;
    logic             load;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ready_en;
    logic             done_q;
    logic             done_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             cmp_q;
    logic             cmp_nxt;

    logic [3:0]       op_q;
    logic [3:0]       dst_q;
    logic [3:0]       srca_q;
    logic [3:0]       srcb_q;
    logic             is_alu;
    logic             is_cmp;
    logic             is_cor;
    logic             is_ldi;

    assign op_q   = instr_q[15:12];
    assign dst_q  = instr_q[11:8];
    assign srca_q = instr_q[7:4];
    assign srcb_q = instr_q[3:0];

    // Decode of the latched instruction; opcodes 0..8 all go through the ALU.
    always_comb begin
        is_alu = (op_q <= OP_CMP);
        is_cmp = (op_q == OP_CMP);
        is_cor = (op_q == OP_COR);
        is_ldi = (op_q == OP_LDI);
    end

    // ready_en keeps instr_ready low until the first clock after reset release.
    assign instr_ready = (state == S_IDLE) && ready_en;
    assign busy        = (state != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign cmp_flag    = cmp_q;

    // Read selects and ALU op code hold from READ until retire, zero while idle.
    always_comb begin
        seloutA = 4'd0;
        seloutB = 4'd0;
        opr     = 4'd0;
        if (state != S_IDLE) begin
            seloutA = srca_q;
            seloutB = srcb_q;
            if (is_alu) begin
                opr = op_q;
            end
        end
    end

    // State register plus the sticky flags, retire pulse and wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            instr_q  <= 16'd0;
            cnt      <= '0;
            ready_en <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cmp_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready_en <= 1'b1;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
            cmp_q    <= cmp_nxt;
            if (load) begin
                instr_q <= instr;
            end
        end
    end

    // Next-state and datapath strobes for the IDLE->READ->ISSUE->WAIT->WB flow.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        load          = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = err_q;
        cmp_nxt       = cmp_q;
        enrregA       = 1'b0;
        enrregB       = 1'b0;
        selwreg       = 4'd0;
        regwen        = 1'b0;
        wb_sel        = WB_ALU;
        alu_start     = 1'b0;
        cordic_start  = 1'b0;
        cordic_enable = 1'b0;

        case (state)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    load    = 1'b1;
                    err_nxt = 1'b0;
                    if (instr[15:12] == OP_NOP) begin
                        // NOP never touches the datapath: retire straight from IDLE.
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end

            S_READ: begin
                // Operands are captured here, so dst may alias a source safely.
                enrregA   = 1'b1;
                enrregB   = 1'b1;
                state_nxt = S_ISSUE;
            end

            S_ISSUE: begin
                cnt_nxt = '0;
                if (is_alu) begin
                    alu_start = 1'b1;
                    state_nxt = S_WAIT;
                end else if (is_cor) begin
                    cordic_start  = 1'b1;
                    cordic_enable = 1'b1;
                    state_nxt     = S_WAIT;
                end else if (is_ldi) begin
                    state_nxt = S_WB;
                end else begin
                    // Opcodes 11..14: flag and retire without touching the bank.
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end

            S_WAIT: begin
                if (is_cor) begin
                    cordic_enable = 1'b1;
                    if (cnt == COR_LAST) begin
                        state_nxt = S_WB;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (alu_done) begin
                    // alu_done is only looked at from WAIT on, so a stale done during ISSUE is ignored.
                    if (is_cmp) begin
                        cmp_nxt = alu_res0;
                    end
                    state_nxt = S_WB;
                end else if (cnt == ALU_LAST) begin
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_WB: begin
                // Compare passes through WB to keep ALU latency uniform, but never writes.
                if (!is_cmp) begin
                    regwen  = 1'b1;
                    selwreg = dst_q;
                    if (is_cor) begin
                        wb_sel = WB_COR;
                    end else if (is_ldi) begin
                        wb_sel = WB_IMM;
                    end else begin
                        wb_sel = WB_ALU;
                    end
                end
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Testbench for calc_seq_ctrl: behavioural datapath around the DUT plus an instruction-level reference model.
// Expected retire records are queued at accept; a monitor pops and compares on every done pulse.
// Randomized instruction stream follows the directed sequence.
module tb_calc_seq_ctrl;

    localparam int CL = 32;
    localparam int TO = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        instr_ready;
    logic [3:0]  seloutA, seloutB, selwreg, opr;
    logic        enrregA, enrregB, regwen;
    logic [1:0]  wb_sel;
    logic        alu_start, alu_done, alu_res0;
    logic        cordic_start, cordic_enable, cmp_flag, busy, done, err;

    calc_seq_ctrl #(.CORDIC_LAT(CL), .ALU_TIMEOUT(TO), .IMM_W(64)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .seloutA(seloutA), .seloutB(seloutB),
        .enrregA(enrregA), .enrregB(enrregB), .selwreg(selwreg), .regwen(regwen),
        .wb_sel(wb_sel), .opr(opr), .alu_start(alu_start), .alu_done(alu_done),
        .alu_res0(alu_res0), .cordic_start(cordic_start), .cordic_enable(cordic_enable),
        .cmp_flag(cmp_flag), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    logic [28:0] outvec;
    assign outvec = {instr_ready, seloutA, seloutB, enrregA, enrregB, selwreg, regwen,
                     wb_sel, opr, alu_start, cordic_start, cordic_enable, cmp_flag, busy, done, err};

    typedef struct {
        int acc; int lat; int wr; int dst; int wbs; int err; int cmp; int cen;
    } exp_t;

    exp_t sbq[$];
    real  eq_re[$];
    real  eq_im[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Datapath stand-in state
    real bank_re[16], bank_im[16];
    real opa_re, opa_im, opb_re, opb_im, res_re, res_im, cor_re, cor_im, imm_re, imm_im;
    logic res_bit;
    int  pend;
    int  alu_dly;

    // Reference model architectural state
    real m_re[16], m_im[16];
    int  m_err, m_cmp;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_r(input string name, input real act, input real exp, input real tol);
        real d;
        n_cmp++;
        d = act - exp;
        if (d < 0.0) d = -d;
        if (!(d <= tol)) begin
            n_fail++;
            $display("FAIL %s: got %f, expected %f (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Complex ALU of the datapath: 0 A, 1 B, 2 A+B, 3 A-B, 4 A*B, 5 B-A, 6 conj A, 7 i*A.
    function automatic void alu_fn(input int op, input real ar, input real ai, input real br,
                                   input real bi, output real rr, output real ri);
        case (op)
            0: begin rr = ar; ri = ai; end
            1: begin rr = br; ri = bi; end
            2: begin rr = ar + br; ri = ai + bi; end
            3: begin rr = ar - br; ri = ai - bi; end
            4: begin rr = ar * br - ai * bi; ri = ar * bi + ai * br; end
            5: begin rr = br - ar; ri = bi - ai; end
            6: begin rr = ar; ri = -ai; end
            7: begin rr = -ai; ri = ar; end
            default: begin rr = 0.0; ri = 0.0; end
        endcase
    endfunction

    function automatic void rec2pol(input real re, input real im, output real md, output real ang);
        md  = $sqrt(re * re + im * im);
        ang = $atan2(im, re) * 180.0 / 3.14159265358979;
    endfunction

    initial begin : cycle_count
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // Datapath responder: reg bank, ALU with programmable done delay (0 = never), CORDIC.
    initial begin : datapath
        for (int i = 0; i < 16; i++) begin
            bank_re[i] = 0.0;
            bank_im[i] = 0.0;
        end
        pend = 0; alu_done = 1'b0; alu_res0 = 1'b0; res_bit = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                pend = 0; alu_done = 1'b0; alu_res0 = 1'b0;
            end else begin
                alu_done = 1'b0;
                alu_res0 = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        alu_done = 1'b1;
                        alu_res0 = res_bit;
                    end
                end
                if (enrregA) begin opa_re = bank_re[seloutA]; opa_im = bank_im[seloutA]; end
                if (enrregB) begin opb_re = bank_re[seloutB]; opb_im = bank_im[seloutB]; end
                if (alu_start) begin
                    alu_fn(int'(opr), opa_re, opa_im, opb_re, opb_im, res_re, res_im);
                    res_bit = (opa_re == opb_re && opa_im == opb_im);
                    pend = alu_dly;
                end
                if (cordic_start) rec2pol(opa_re, opa_im, cor_re, cor_im);
                if (regwen) begin
                    case (wb_sel)
                        2'd0: begin bank_re[selwreg] = res_re; bank_im[selwreg] = res_im; end
                        2'd1: begin bank_re[selwreg] = cor_re; bank_im[selwreg] = cor_im; end
                        default: begin bank_re[selwreg] = imm_re; bank_im[selwreg] = imm_im; end
                    endcase
                end
            end
        end
    end

    // Instruction-level model: what each instruction should do, decided at accept time.
    task automatic model_push(input int op, input int dst, input int a, input int b,
                              input int dly, input real ire, input real iim);
        exp_t e;
        real rr, ri;
        e.acc = cyc; e.dst = dst; e.wr = 0; e.wbs = 0; e.cen = 0; e.lat = 0;
        m_err = 0;
        if (op == 15) begin
            e.lat = 1;
        end else if (op >= 11) begin
            e.lat = 3; m_err = 1;
        end else if (op == 10) begin
            e.lat = 4; e.wr = 1; e.wbs = 2;
            m_re[dst] = ire; m_im[dst] = iim;
        end else if (op == 9) begin
            e.lat = CL + 4; e.wr = 1; e.wbs = 1; e.cen = CL + 1;
            rec2pol(m_re[a], m_im[a], rr, ri);
            m_re[dst] = rr; m_im[dst] = ri;
        end else if (dly == 0) begin
            e.lat = 2 + TO + 1; m_err = 1;
        end else begin
            e.lat = dly + 4;
            if (op == 8) begin
                m_cmp = (m_re[a] == m_re[b] && m_im[a] == m_im[b]) ? 1 : 0;
            end else begin
                e.wr = 1;
                alu_fn(op, m_re[a], m_im[a], m_re[b], m_im[b], rr, ri);
                m_re[dst] = rr; m_im[dst] = ri;
            end
        end
        e.err = m_err; e.cmp = m_cmp;
        sbq.push_back(e);
        eq_re.push_back(m_re[dst]);
        eq_im.push_back(m_im[dst]);
    endtask

    // Offer an instruction; called at a negedge, returns one negedge after acceptance.
    task automatic issue(input int op, input int dst, input int a, input int b,
                         input int dly, input real ire, input real iim);
        int n;
        instr = {4'(op), 4'(dst), 4'(a), 4'(b)};
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", instr_ready, 1);
            instr_valid = 1'b0;
            return;
        end
        alu_dly = dly;
        if (op == 10) begin imm_re = ire; imm_im = iim; end
        model_push(op, dst, a, b, dly, ire, iim);
        @(negedge clock);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", sbq.size(), 0);
    endtask

    // Scoreboard monitor: on each done pulse, compare the retire against the oldest expectation.
    initial begin : monitor
        exp_t e;
        real er, ei;
        int nreg, ncen, stall, lsel, lwbs;
        nreg = 0; ncen = 0; stall = 0; lsel = 0; lwbs = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                nreg = 0; ncen = 0; stall = 0;
            end else begin
                if (cordic_enable) ncen++;
                if (regwen) begin nreg++; lsel = int'(selwreg); lwbs = int'(wb_sel); end
                if (done) begin
                    if (sbq.size() == 0) begin
                        chk("done_without_pending", done, 0);
                    end else begin
                        e = sbq.pop_front();
                        er = eq_re.pop_front();
                        ei = eq_im.pop_front();
                        chk("latency", cyc - e.acc, e.lat);
                        chk("regwen_pulses", nreg, e.wr);
                        if (e.wr != 0) begin
                            chk("selwreg", lsel, e.dst);
                            chk("wb_sel", lwbs, e.wbs);
                        end
                        chk("err", err, e.err);
                        chk("cmp_flag", cmp_flag, e.cmp);
                        chk("cordic_enable_cycles", ncen, e.cen);
                        chk("busy_at_done", busy, 0);
                        chk_r("dst_re", bank_re[e.dst], er, 1e-6);
                        chk_r("dst_im", bank_im[e.dst], ei, 1e-6);
                    end
                    nreg = 0; ncen = 0; stall = 0;
                end else if (sbq.size() != 0) begin
                    stall++;
                    if (stall > 300) begin
                        chk("retire_timeout", done, 1);
                        e = sbq.pop_front();
                        er = eq_re.pop_front();
                        ei = eq_im.pop_front();
                        stall = 0;
                    end
                end else begin
                    stall = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int op, dst, a, b, dly;
        real ire, iim;
        for (int i = 0; i < 16; i++) begin m_re[i] = 0.0; m_im[i] = 0.0; end
        m_err = 0; m_cmp = 0; alu_dly = 1; imm_re = 0.0; imm_im = 0.0;

        // Reset state
        #1;
        chk("reset_outputs_zero", outvec, 0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 chk("ready_low_before_first_clock", instr_ready, 0);
        @(negedge clock);
        chk("ready_after_release", instr_ready, 1);
        chk("busy_idle", busy, 0);

        // Directed program
        issue(10, 0, 0, 0, 0, 20.0, 20.0);
        issue(10, 1, 0, 0, 0, 20.0, 20.0);
        issue(2, 2, 0, 1, 3, 0.0, 0.0);
        issue(3, 3, 0, 1, 2, 0.0, 0.0);
        issue(4, 4, 0, 1, 5, 0.0, 0.0);
        issue(8, 0, 0, 1, 1, 0.0, 0.0);
        issue(8, 0, 0, 3, 4, 0.0, 0.0);
        issue(9, 6, 0, 0, 0, 0.0, 0.0);
        issue(2, 7, 0, 1, 0, 0.0, 0.0);
        issue(12, 9, 0, 1, 1, 0.0, 0.0);
        issue(15, 0, 0, 0, 0, 0.0, 0.0);
        drain();
        chk_r("R2_re", bank_re[2], 40.0, 1e-9);
        chk_r("R2_im", bank_im[2], 40.0, 1e-9);
        chk_r("R3_re", bank_re[3], 0.0, 1e-9);
        chk_r("R4_re", bank_re[4], 0.0, 1e-9);
        chk_r("R4_im", bank_im[4], 800.0, 1e-9);
        chk_r("R6_mod", bank_re[6], 28.284, 0.001);
        chk_r("R6_angle", bank_im[6], 45.0, 0.001);
        chk_r("R7_untouched", bank_re[7], 0.0, 1e-9);

        // dst aliases srcA
        issue(2, 1, 1, 0, 2, 0.0, 0.0);
        drain();
        chk_r("R1_alias_re", bank_re[1], 40.0, 1e-9);

        // Reset in the middle of a MUL wait
        issue(4, 5, 0, 1, 0, 0.0, 0.0);
        repeat (6) @(negedge clock);
        chk("busy_before_reset", busy, 1);
        #2 reset = 1'b0;
        void'(sbq.pop_back());
        void'(eq_re.pop_back());
        void'(eq_im.pop_back());
        m_err = 0; m_cmp = 0;
        #1 chk("midwait_reset_outputs_zero", outvec, 0);
        @(negedge clock);
        chk("regwen_in_reset", regwen, 0);
        #2 reset = 1'b1;
        #1 chk("ready_low_after_midreset", instr_ready, 0);
        @(negedge clock);
        chk("ready_after_midreset", instr_ready, 1);
        chk_r("R5_not_written", bank_re[5], 0.0, 1e-9);
        issue(2, 5, 0, 2, 2, 0.0, 0.0);
        drain();
        chk_r("R5_after_reset_add", bank_re[5], 60.0, 1e-9);

        // Randomized instruction stream
        for (int i = 0; i < 30; i++) begin
            op  = int'($urandom_range(0, 15));
            if (op == 4) op = 2;
            dst = int'($urandom_range(0, 15));
            a   = int'($urandom_range(0, 15));
            b   = int'($urandom_range(0, 15));
            dly = ($urandom_range(0, 14) == 0) ? 0 : int'($urandom_range(1, 6));
            ire = real'($urandom_range(0, 10)) - 5.0;
            iim = real'($urandom_range(0, 10)) - 5.0;
            issue(op, dst, a, b, dly, ire, iim);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
